// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake
//   clk, rst (async, active-high), start, A[WIDTH-1:0] -> busy, done, bcd[4*DIGITS-1:0], ovf
//   optional BCD_BLANK_EN adds blank[DIGITS-1:0] (leading-zero flags, updated with bcd)
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      A,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [31:0] LIM = 32'(10 ** DIGITS);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   scr_q, scr_d, adj;
    logic            pend_q, pend_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        pend_d  = pend_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_BLANK_EN
        blank_d = blank_q;
`endif
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
        case (state_q)
            IDLE: if (start) begin
                bin_d   = A;
                scr_d   = '0;
                pend_d  = 32'(A) >= LIM;
                cnt_d   = CW'(WIDTH);
                busy_d  = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                // top bit of the adjusted scratch falls off: result is A mod 10^DIGITS
                {scr_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? LOAD : SHIFT;
            end
            LOAD: begin
                bcd_d   = scr_q;
                ovf_d   = pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef BCD_BLANK_EN
                blank_d[0] = 1'b0;
                for (int i = 1; i < DIGITS; i++)
                    blank_d[i] = (scr_q >> (4 * i)) == '0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            pend_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BCD_BLANK_EN
            blank_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            pend_q  <= pend_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef BCD_BLANK_EN
            blank_q <= blank_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;
`ifdef BCD_BLANK_EN
    assign blank = blank_q;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed-vector bench for bin2bcd_seq (WIDTH=8 with DIGITS=3 and DIGITS=2)
module tb_bin2bcd_seq;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, start2 = 1'b0;
    logic [7:0] a = '0, a2 = '0;
    logic busy, done, ovf, busy2, done2, ovf2;
    logic [11:0] bcd;
    logic [7:0] bcd2;
`ifdef BCD_BLANK_EN
    logic [2:0] blank;
    logic [1:0] blank2;
`endif
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .A(a), .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
`ifdef BCD_BLANK_EN
        , .blank(blank)
`endif
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
`ifdef BCD_BLANK_EN
        , .blank(blank2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int sel, input logic [7:0] v);
        if (sel == 0) begin a = v; start = 1'b1; end
        else begin a2 = v; start2 = 1'b1; end
        step();
        chk("busy_rise", 32'(sel == 0 ? busy : busy2), 1);
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int sel, output int lat);
        lat = 0;
        while (lat < 30) begin
            step();
            lat++;
            if ((sel == 0 ? done : done2) === 1'b1) break;
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            step();
            if (done) n++;
        end
    endtask

    int lat, n;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bcd", 32'(bcd), 0);
        chk("rst_ovf", 32'(ovf), 0);

        go(0, 8'd77);
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        count_done(12, n);
        chk("mid_rst_nodone", n, 0);
        chk("mid_rst_bcd", 32'(bcd), 0);

        go(0, 8'd255);
        wait_done(0, lat);
        chk("lat_255", lat, 9);
        chk("bcd_255", 32'(bcd), 32'h255);
        chk("ovf_255", 32'(ovf), 0);
        chk("busy_done", 32'(busy), 0);
`ifdef BCD_BLANK_EN
        chk("blank_255", 32'(blank), 32'b000);
`endif
        step();
        chk("done_pulse", 32'(done), 0);
        chk("bcd_hold", 32'(bcd), 32'h255);

        go(0, 8'd0);
        wait_done(0, lat);
        chk("bcd_0", 32'(bcd), 32'h000);
        chk("ovf_0", 32'(ovf), 0);
`ifdef BCD_BLANK_EN
        chk("blank_0", 32'(blank), 32'b110);
`endif
        go(0, 8'd99);
        wait_done(0, lat);
        chk("lat_99", lat, 9);
        chk("bcd_99", 32'(bcd), 32'h099);
`ifdef BCD_BLANK_EN
        chk("blank_99", 32'(blank), 32'b100);
`endif

        go(0, 8'd37);
        repeat (3) step();
        a = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, lat);
        chk("lat_37", lat, 5);
        chk("bcd_37", 32'(bcd), 32'h037);
        count_done(20, n);
        chk("ignored_start", n, 0);

        go(0, 8'd128);
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_bcd", 32'(bcd), 0);
        repeat (2) step();
        rst = 1'b0;
        count_done(15, n);
        chk("async_nodone", n, 0);

        go(1, 8'd200);
        wait_done(1, lat);
        chk("lat_d2", lat, 9);
        chk("bcd_200", 32'(bcd2), 32'h00);
        chk("ovf_200", 32'(ovf2), 1);
`ifdef BCD_BLANK_EN
        chk("blank_200", 32'(blank2), 32'b10);
`endif
        go(1, 8'd42);
        wait_done(1, lat);
        chk("bcd_42", 32'(bcd2), 32'h42);
        chk("ovf_42", 32'(ovf2), 0);
`ifdef BCD_BLANK_EN
        chk("blank_42", 32'(blank2), 32'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
